// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: opcodes, scoreboard entry, FSM states and operand-use decode shared by the hazard controller.
package hazard_ctrl_pkg;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

    typedef enum logic [1:0] {RUN, STALL, FLUSH} hz_state_e;

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op inside {OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL});
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op inside {OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH};
    endfunction

    function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] rd);
        return !(op inside {OPCODE_STORE, OPCODE_BRANCH}) && rd != 5'd0;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: EX/MEM/WB destination shadow and RAW match against the decode instruction.
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int SB_DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec_valid_i,
    input  logic [6:0] dec_opcode_i,
    input  logic [4:0] dec_rd_i,
    input  logic [4:0] dec_rs1_i,
    input  logic [4:0] dec_rs2_i,
    input  logic       fwd_en_i,
    input  logic       issue_i,
    output logic       hazard_o
);

    sb_entry_t sb [SB_DEPTH];
    logic      u1;
    logic      u2;
    logic      hz;

    assign u1 = uses_rs1(dec_opcode_i) && dec_rs1_i != 5'd0;
    assign u2 = uses_rs2(dec_opcode_i) && dec_rs2_i != 5'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SB_DEPTH; i++) sb[i] <= '0;
        end else begin
            sb[0] <= issue_i ? {writes_rd(dec_opcode_i, dec_rd_i), dec_rd_i, dec_opcode_i == OPCODE_LOAD} : '0;
            for (int i = 1; i < SB_DEPTH; i++) sb[i] <= sb[i-1];
        end
    end

    // With forwarding only a load still in EX can't supply its result in time.
    always_comb begin
        hz = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++)
            if (sb[i].valid && (!fwd_en_i || (i == 0 && sb[i].is_load)) &&
                ((u1 && dec_rs1_i == sb[i].rd) || (u2 && dec_rs2_i == sb[i].rd)))
                hz = 1'b1;
        hazard_o = dec_valid_i && hz;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: decode-stage sequencer for RAW stalls, branch redirect/flush and stall/flush perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int AWIDTH       = 32,
    parameter int SB_DEPTH     = 3,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid_i,
    input  logic [6:0]        dec_opcode_i,
    input  logic [4:0]        dec_rd_i,
    input  logic [4:0]        dec_rs1_i,
    input  logic [4:0]        dec_rs2_i,
    input  logic              fwd_en_i,
    input  logic              br_taken_i,
    input  logic [AWIDTH-1:0] br_target_i,
    output logic              stall_fd_o,
    output logic              bubble_ex_o,
    output logic              flush_o,
    output logic              redirect_valid_o,
    output logic [AWIDTH-1:0] redirect_pc_o,
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o
);

    hz_state_e  state;
    logic [2:0] fcnt;
    logic       hazard;
    logic       issue;

    hazard_scoreboard #(.SB_DEPTH(SB_DEPTH)) u_sb (
        .clk          (clk),
        .rst          (rst),
        .dec_valid_i  (dec_valid_i),
        .dec_opcode_i (dec_opcode_i),
        .dec_rd_i     (dec_rd_i),
        .dec_rs1_i    (dec_rs1_i),
        .dec_rs2_i    (dec_rs2_i),
        .fwd_en_i     (fwd_en_i),
        .issue_i      (issue),
        .hazard_o     (hazard)
    );

    assign flush_o     = state == FLUSH;
    assign stall_fd_o  = hazard && !br_taken_i && !flush_o;
    assign bubble_ex_o = !dec_valid_i || stall_fd_o || br_taken_i || flush_o;
    assign issue       = dec_valid_i && !stall_fd_o && !bubble_ex_o;

    // A taken branch always wins, including restarting an in-progress flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            fcnt  <= '0;
        end else if (br_taken_i) begin
            state <= FLUSH;
            fcnt  <= 3'(FLUSH_CYCLES);
        end else if (state == FLUSH) begin
            state <= (fcnt == 3'd1) ? RUN : FLUSH;
            fcnt  <= fcnt - 3'd1;
        end else begin
            state <= hazard ? STALL : RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
        end else begin
            redirect_valid_o <= br_taken_i;
            if (br_taken_i) redirect_pc_o <= br_target_i & ~AWIDTH'(3);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_fd_o && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 32'd1;
            if (br_taken_i && !(&flush_cnt_o)) flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed table, randomized run against an age-based reference model, and async reset check.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int FC = 2;

    logic        clk;
    logic        rst;
    logic        dec_valid_i;
    logic [6:0]  dec_opcode_i;
    logic [4:0]  dec_rd_i;
    logic [4:0]  dec_rs1_i;
    logic [4:0]  dec_rs2_i;
    logic        fwd_en_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic        stall_fd_o;
    logic        bubble_ex_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    hazard_ctrl #(.AWIDTH(32), .SB_DEPTH(3), .FLUSH_CYCLES(FC)) dut (
        .clk              (clk),
        .rst              (rst),
        .dec_valid_i      (dec_valid_i),
        .dec_opcode_i     (dec_opcode_i),
        .dec_rd_i         (dec_rd_i),
        .dec_rs1_i        (dec_rs1_i),
        .dec_rs2_i        (dec_rs2_i),
        .fwd_en_i         (fwd_en_i),
        .br_taken_i       (br_taken_i),
        .br_target_i      (br_target_i),
        .stall_fd_o       (stall_fd_o),
        .bubble_ex_o      (bubble_ex_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .stall_cnt_o      (stall_cnt_o),
        .flush_cnt_o      (flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: destination written by the instruction at each age past decode.
    int          m_dst [3];
    bit          m_ld  [3];
    int          m_flush;
    bit          m_rv;
    logic [31:0] m_pc;
    logic [31:0] m_sc;
    logic [31:0] m_fc;
    logic        g_stall, g_bub, g_flush;

    typedef struct {
        logic [2:0]  ctl;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] tgt;
        logic [2:0]  exp;
    } vec_t;

    vec_t tbl [26];
    logic [6:0] ops [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 3; a++) begin
            m_dst[a] = 0;
            m_ld[a]  = 0;
        end
        m_flush = 0;
        m_rv    = 0;
        m_pc    = '0;
        m_sc    = '0;
        m_fc    = '0;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input logic v, input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic fwd, input logic br, input logic [31:0] tgt);
        bit u1, u2, wr, hz, e_stall, e_flush, e_bub;
        dec_valid_i  = v;
        dec_opcode_i = op;
        dec_rd_i     = rd;
        dec_rs1_i    = rs1;
        dec_rs2_i    = rs2;
        fwd_en_i     = fwd;
        br_taken_i   = br;
        br_target_i  = tgt;
        #3;
        u1 = !(op inside {OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL});
        u2 = op inside {OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH};
        wr = !(op inside {OPCODE_STORE, OPCODE_BRANCH});
        hz = 0;
        if (v)
            for (int a = 0; a < 3; a++)
                if ((!fwd || (a == 0 && m_ld[0])) && m_dst[a] != 0 &&
                    ((u1 && int'(rs1) == m_dst[a]) || (u2 && int'(rs2) == m_dst[a])))
                    hz = 1;
        e_flush = m_flush > 0;
        e_stall = hz && !br && !e_flush;
        e_bub   = !v || e_stall || br || e_flush;
        g_stall = stall_fd_o;
        g_bub   = bubble_ex_o;
        g_flush = flush_o;
        check("stall_fd", 32'(stall_fd_o), 32'(e_stall));
        check("bubble_ex", 32'(bubble_ex_o), 32'(e_bub));
        check("flush", 32'(flush_o), 32'(e_flush));
        check("redirect_valid", 32'(redirect_valid_o), 32'(m_rv));
        check("redirect_pc", redirect_pc_o, m_pc);
        check("stall_cnt", stall_cnt_o, m_sc);
        check("flush_cnt", flush_cnt_o, m_fc);
        @(posedge clk);
        #1;
        for (int a = 2; a > 0; a--) begin
            m_dst[a] = m_dst[a-1];
            m_ld[a]  = m_ld[a-1];
        end
        m_dst[0] = (!e_bub && wr) ? int'(rd) : 0;
        m_ld[0]  = !e_bub && op == OPCODE_LOAD;
        m_flush  = br ? FC : (e_flush ? m_flush - 1 : 0);
        m_rv     = br;
        if (br) m_pc = {tgt[31:2], 2'b00};
        if (e_stall && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        if (br && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
    endtask

    initial begin
        ops = '{OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH, OPCODE_JAL, OPCODE_JALR,
                OPCODE_LUI, OPCODE_AUIPC, OPCODE_OP, OPCODE_OPIMM, 7'h7f};
        // ctl = {valid, fwd, br}; exp = {stall, bubble, flush}
        tbl[0]  = '{3'b110, OPCODE_LOAD,  5'd5,  5'd1,  5'd0, 32'h0,       3'b000};
        tbl[1]  = '{3'b110, OPCODE_OP,    5'd6,  5'd5,  5'd1, 32'h0,       3'b110};
        tbl[2]  = '{3'b110, OPCODE_OP,    5'd6,  5'd5,  5'd1, 32'h0,       3'b000};
        tbl[3]  = '{3'b010, OPCODE_OP,    5'd0,  5'd0,  5'd0, 32'h0,       3'b010};
        tbl[4]  = '{3'b010, OPCODE_OP,    5'd0,  5'd0,  5'd0, 32'h0,       3'b010};
        tbl[5]  = '{3'b010, OPCODE_OP,    5'd0,  5'd0,  5'd0, 32'h0,       3'b010};
        tbl[6]  = '{3'b100, OPCODE_OPIMM, 5'd3,  5'd0,  5'd0, 32'h0,       3'b000};
        tbl[7]  = '{3'b100, OPCODE_OP,    5'd4,  5'd3,  5'd3, 32'h0,       3'b110};
        tbl[8]  = '{3'b100, OPCODE_OP,    5'd4,  5'd3,  5'd3, 32'h0,       3'b110};
        tbl[9]  = '{3'b100, OPCODE_OP,    5'd4,  5'd3,  5'd3, 32'h0,       3'b110};
        tbl[10] = '{3'b100, OPCODE_OP,    5'd4,  5'd3,  5'd3, 32'h0,       3'b000};
        tbl[11] = '{3'b100, OPCODE_OPIMM, 5'd0,  5'd1,  5'd0, 32'h0,       3'b000};
        tbl[12] = '{3'b100, OPCODE_OP,    5'd8,  5'd0,  5'd0, 32'h0,       3'b000};
        tbl[13] = '{3'b100, OPCODE_LUI,   5'd7,  5'd8,  5'd8, 32'h0,       3'b000};
        tbl[14] = '{3'b100, OPCODE_JAL,   5'd1,  5'd7,  5'd7, 32'h0,       3'b000};
        tbl[15] = '{3'b101, OPCODE_OP,    5'd9,  5'd7,  5'd0, 32'h0000_1003, 3'b010};
        tbl[16] = '{3'b100, OPCODE_OP,    5'd10, 5'd1,  5'd2, 32'h0,       3'b011};
        tbl[17] = '{3'b100, OPCODE_OP,    5'd10, 5'd1,  5'd2, 32'h0,       3'b011};
        tbl[18] = '{3'b100, OPCODE_OP,    5'd10, 5'd1,  5'd2, 32'h0,       3'b000};
        tbl[19] = '{3'b100, OPCODE_OP,    5'd11, 5'd10, 5'd0, 32'h0,       3'b110};
        tbl[20] = '{3'b101, OPCODE_OP,    5'd11, 5'd10, 5'd0, 32'h0000_2006, 3'b010};
        tbl[21] = '{3'b100, OPCODE_OP,    5'd11, 5'd10, 5'd0, 32'h0,       3'b011};
        tbl[22] = '{3'b101, OPCODE_OP,    5'd11, 5'd10, 5'd0, 32'h0000_3001, 3'b011};
        tbl[23] = '{3'b100, OPCODE_OP,    5'd11, 5'd10, 5'd0, 32'h0,       3'b011};
        tbl[24] = '{3'b100, OPCODE_OP,    5'd11, 5'd10, 5'd0, 32'h0,       3'b011};
        tbl[25] = '{3'b100, OPCODE_OP,    5'd11, 5'd10, 5'd0, 32'h0,       3'b000};

        rst = 1'b0;
        dec_valid_i = 1'b0; dec_opcode_i = '0; dec_rd_i = '0; dec_rs1_i = '0; dec_rs2_i = '0;
        fwd_en_i = 1'b0; br_taken_i = 1'b0; br_target_i = '0;
        model_reset();
        #12;
        check("reset stall_fd", 32'(stall_fd_o), 32'd0);
        check("reset bubble_ex", 32'(bubble_ex_o), 32'd1);
        check("reset flush", 32'(flush_o), 32'd0);
        check("reset redirect_valid", 32'(redirect_valid_o), 32'd0);
        check("reset redirect_pc", redirect_pc_o, 32'd0);
        check("reset stall_cnt", stall_cnt_o, 32'd0);
        check("reset flush_cnt", flush_cnt_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 26; i++) begin
            step(tbl[i].ctl[2], tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].ctl[1], tbl[i].ctl[0], tbl[i].tgt);
            check($sformatf("row%0d stall", i), 32'(g_stall), 32'(tbl[i].exp[2]));
            check($sformatf("row%0d bubble", i), 32'(g_bub), 32'(tbl[i].exp[1]));
            check($sformatf("row%0d flush", i), 32'(g_flush), 32'(tbl[i].exp[0]));
            if (i == 15) begin
                check("branch redirect_valid", 32'(redirect_valid_o), 32'd1);
                check("branch redirect_pc", redirect_pc_o, 32'h0000_1000);
            end
            if (i == 22) check("second redirect_pc", redirect_pc_o, 32'h0000_3000);
        end
        check("table stall_cnt", stall_cnt_o, 32'd5);
        check("table flush_cnt", flush_cnt_o, 32'd3);

        for (int n = 0; n < 1500; n++)
            step($urandom_range(0, 9) != 0, ops[$urandom_range(0, 9)], 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 11) == 0, $urandom);

        step(1'b1, OPCODE_OP, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1, 32'h0000_4000);
        #1;
        check("pre-reset flush", 32'(flush_o), 32'd1);
        check("pre-reset redirect_valid", 32'(redirect_valid_o), 32'd1);
        rst = 1'b0;
        #1;
        check("async flush", 32'(flush_o), 32'd0);
        check("async redirect_valid", 32'(redirect_valid_o), 32'd0);
        check("async redirect_pc", redirect_pc_o, 32'd0);
        check("async stall_cnt", stall_cnt_o, 32'd0);
        check("async flush_cnt", flush_cnt_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        step(1'b1, OPCODE_OP, 5'd2, 5'd3, 5'd4, 1'b0, 1'b0, 32'h0);
        check("post-reset run bubble", 32'(g_bub), 32'd0);
        step(1'b1, OPCODE_OP, 5'd5, 5'd2, 5'd0, 1'b0, 1'b0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
